// File: rtl/gray_counter_updn.sv
// Registered up/down binary counter publishing its Gray code and a terminal-count flag.
// Define GRAY_CNT_SAT_EN to saturate at the range ends instead of wrapping.
module gray_counter_updn #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] ZERO_VAL = '0;

  logic [WIDTH-1:0] bin_nxt_c;
  logic [WIDTH-1:0] gray_nxt_c;
  logic             tc_nxt_c;
  logic             at_bound_c;

  // Next binary value and terminal flag; load outranks a step, a step outranks hold.
  always_comb begin
    bin_nxt_c  = bin_o;
    tc_nxt_c   = 1'b0;
    at_bound_c = up_i ? (bin_o == MAX_VAL) : (bin_o == ZERO_VAL);
    if (load_i) begin
      bin_nxt_c = load_val_i;
    end else if (en_i) begin
`ifdef GRAY_CNT_SAT_EN
      // A step past either end is blocked and flagged.
      if (at_bound_c) begin
        tc_nxt_c = 1'b1;
      end else begin
        bin_nxt_c = up_i ? (bin_o + WIDTH'(1)) : (bin_o - WIDTH'(1));
      end
`else
      bin_nxt_c = up_i ? (bin_o + WIDTH'(1)) : (bin_o - WIDTH'(1));
      tc_nxt_c  = at_bound_c;
`endif
    end
  end

  // Gray is derived from the next binary value so both registers update together.
  assign gray_nxt_c = bin_nxt_c ^ (bin_nxt_c >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_o  <= '0;
      gray_o <= '0;
      tc_o   <= 1'b0;
    end else begin
      bin_o  <= bin_nxt_c;
      gray_o <= gray_nxt_c;
      tc_o   <= tc_nxt_c;
    end
  end

endmodule
